// File: rtl/prog_fsm.sv
// Table-driven Moore FSM: next state and output come from writable tables
// that are loaded while halted and survive reset.
module prog_fsm #(
    parameter int unsigned IN_W        = 2,
    parameter int unsigned ST_W        = 3,
    parameter int unsigned OUT_W       = 3,
    parameter int unsigned NUM_STATES  = 8,
    parameter int unsigned RESET_STATE = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       run,
    input  logic [IN_W-1:0]                            a,
    input  logic                                       cfg_valid,
    output logic                                       cfg_ready,
    input  logic                                       cfg_sel,
    input  logic [ST_W+IN_W-1:0]                       cfg_addr,
    input  logic [((ST_W > OUT_W) ? ST_W : OUT_W)-1:0] cfg_data,
    input  logic                                       clr_cnt,
    output logic [ST_W-1:0]                            state_o,
    output logic [OUT_W-1:0]                           saida,
    output logic                                       changed,
    output logic                                       err,
    output logic [CNT_W-1:0]                           trans_cnt
);

    localparam int unsigned     TR_DEPTH  = 1 << (ST_W + IN_W);
    localparam int unsigned     OUT_DEPTH = 1 << ST_W;
    localparam logic [ST_W-1:0] RST_ST    = ST_W'(RESET_STATE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [ST_W-1:0]  trans_tbl [TR_DEPTH];
    logic [OUT_W-1:0] out_tbl   [OUT_DEPTH];

    logic             cfg_we;
    logic [ST_W-1:0]  nxt_raw;
    logic [ST_W-1:0]  nxt;
    logic             illegal;
    logic [ST_W-1:0]  state_d;
    logic [OUT_W-1:0] saida_d;
    logic             changed_d;
    logic             err_d;
    logic [CNT_W-1:0] cnt_d;

    assign cfg_ready = ~run;
    assign cfg_we    = cfg_valid & ~run & ~reset;

    // Table storage has no reset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            if (!cfg_sel) begin
                trans_tbl[cfg_addr] <= cfg_data[ST_W-1:0];
            end else begin
                out_tbl[cfg_addr[ST_W-1:0]] <= cfg_data[OUT_W-1:0];
            end
        end
    end

    assign nxt_raw = trans_tbl[{state_o, a}];
    assign illegal = 32'(nxt_raw) >= NUM_STATES;
    assign nxt     = illegal ? RST_ST : nxt_raw;

    always_comb begin
        state_d   = state_o;
        saida_d   = saida;
        changed_d = 1'b0;
        err_d     = 1'b0;
        cnt_d     = trans_cnt;
        if (run) begin
            state_d   = nxt;
            saida_d   = out_tbl[nxt];
            changed_d = (nxt != state_o);
            err_d     = illegal;
            if (changed_d && (trans_cnt != CNT_MAX)) begin
                cnt_d = trans_cnt + CNT_W'(1);
            end
        end
        // Clear wins over a same-cycle increment.
        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_o   <= RST_ST;
            saida     <= '0;
            changed   <= 1'b0;
            err       <= 1'b0;
            trans_cnt <= '0;
        end else begin
            state_o   <= state_d;
            saida     <= saida_d;
            changed   <= changed_d;
            err       <= err_d;
            trans_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_prog_fsm.sv
// Self-checking bench for prog_fsm: directed scenarios plus randomized traffic
// against a behavioural table/arithmetic reference model.
module tb_prog_fsm;

    localparam int unsigned IN_W  = 2;
    localparam int unsigned ST_W  = 3;
    localparam int unsigned OUT_W = 3;
    localparam int unsigned NS    = 6;
    localparam int unsigned RST   = 0;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = 15;

    logic                  clk;
    logic                  reset;
    logic                  run;
    logic [IN_W-1:0]       a;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic                  cfg_sel;
    logic [ST_W+IN_W-1:0]  cfg_addr;
    logic [ST_W-1:0]       cfg_data;
    logic                  clr_cnt;
    logic [ST_W-1:0]       state_o;
    logic [OUT_W-1:0]      saida;
    logic                  changed;
    logic                  err;
    logic [CNT_W-1:0]      trans_cnt;

    int checks = 0;
    int errors = 0;

    int m_trans [32];
    int m_out   [8];
    int m_st, m_sa, m_ch, m_er, m_cnt;

    prog_fsm #(
        .IN_W(IN_W), .ST_W(ST_W), .OUT_W(OUT_W),
        .NUM_STATES(NS), .RESET_STATE(RST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .a(a),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .clr_cnt(clr_cnt),
        .state_o(state_o), .saida(saida), .changed(changed), .err(err),
        .trans_cnt(trans_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: one clock edge applied with the currently driven inputs.
    task automatic model_update();
        int n;
        if (reset) begin
            m_st = RST; m_sa = 0; m_ch = 0; m_er = 0; m_cnt = 0;
        end else begin
            m_ch = 0;
            m_er = 0;
            if (run) begin
                n = m_trans[m_st * 4 + int'(a)];
                if (n >= int'(NS)) begin
                    n    = RST;
                    m_er = 1;
                end
                m_ch = (n != m_st) ? 1 : 0;
                m_st = n;
                m_sa = m_out[n];
                if (m_ch == 1 && m_cnt < CMAX) m_cnt++;
            end
            if (clr_cnt) m_cnt = 0;
            if (cfg_valid && !run) begin
                if (!cfg_sel) m_trans[int'(cfg_addr)] = int'(cfg_data);
                else          m_out[int'(cfg_addr) % 8] = int'(cfg_data);
            end
        end
    endtask

    task automatic step();
        #4;
        chk("cfg_ready", 32'(cfg_ready), 32'(!run));
        @(posedge clk);
        model_update();
        #1;
        chk("state_o", 32'(state_o), 32'(m_st));
        chk("saida", 32'(saida), 32'(m_sa));
        chk("changed", 32'(changed), 32'(m_ch));
        chk("err", 32'(err), 32'(m_er));
        chk("trans_cnt", 32'(trans_cnt), 32'(m_cnt));
    endtask

    task automatic wr(input logic sel, input int addr, input int data);
        run       = 1'b0;
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = 5'(addr);
        cfg_data  = 3'(data);
        step();
        cfg_valid = 1'b0;
    endtask

    function automatic int base_next(input int s, input int av);
        if (s == 0) begin
            case (av)
                0: return 1;
                1: return 7;
                2: return 1;
                default: return 5;
            endcase
        end
        case (av)
            0: return (s + 1) % 8;
            1: return s;
            2: return (s + 2) % 8;
            default: return 0;
        endcase
    endfunction

    initial begin
        reset = 1'b1; run = 1'b0; a = '0; cfg_valid = 1'b0; cfg_sel = 1'b0;
        cfg_addr = '0; cfg_data = '0; clr_cnt = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Program the tables while halted.
        for (int s = 0; s < 8; s++)
            for (int av = 0; av < 4; av++)
                wr(1'b0, s * 4 + av, base_next(s, av));
        for (int s = 0; s < 8; s++)
            wr(1'b1, s, (s == 7) ? 3 : s);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_saida", 32'(saida), 0);
        chk("rst_cnt", 32'(trans_cnt), 0);
        step();
        chk("halt_saida", 32'(saida), 0);

        // Basic stepping from the reset state.
        run = 1'b1; a = 2'd0;
        step();
        chk("run_st1", 32'(state_o), 1);
        chk("run_sa1", 32'(saida), 1);
        chk("run_ch1", 32'(changed), 1);
        step();
        chk("run_st2", 32'(state_o), 2);
        chk("run_sa2", 32'(saida), 2);
        chk("run_cnt2", 32'(trans_cnt), 2);

        // Write while running is dropped.
        a = 2'd1; cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_addr = 5'd8; cfg_data = 3'd6;
        #4;
        chk("drop_ready", 32'(cfg_ready), 0);
        @(posedge clk); model_update(); #1;
        chk("drop_state", 32'(state_o), 2);
        cfg_valid = 1'b0; run = 1'b0;
        step();
        run = 1'b1; a = 2'd0;
        step();
        chk("drop_reread", 32'(state_o), 3);
        chk("drop_err", 32'(err), 0);

        // Illegal next state redirects to the reset state.
        wr(1'b0, 1, 6);
        reset = 1'b1; step(); reset = 1'b0;
        run = 1'b1; a = 2'd1;
        step();
        chk("ill_state", 32'(state_o), 0);
        chk("ill_err", 32'(err), 1);
        chk("ill_changed", 32'(changed), 0);
        run = 1'b0;
        step();
        chk("ill_err_pulse", 32'(err), 0);
        run = 1'b1; a = 2'd3;
        step();
        a = 2'd0;
        step();
        chk("ill5_state", 32'(state_o), 0);
        chk("ill5_err", 32'(err), 1);
        chk("ill5_changed", 32'(changed), 1);

        // Counter saturation and clear priority.
        reset = 1'b1; step(); reset = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = (i % 2 == 1) ? 2'd3 : 2'd0;
            step();
        end
        chk("sat_cnt", 32'(trans_cnt), 15);
        clr_cnt = 1'b1; a = 2'd0;
        step();
        chk("clr_changed", 32'(changed), 1);
        chk("clr_cnt", 32'(trans_cnt), 0);
        clr_cnt = 1'b0; a = 2'd3;
        step();
        chk("clr_recount", 32'(trans_cnt), 1);

        // Reset mid-run at state 5.
        a = 2'd3;
        step();
        chk("pre_rst_state", 32'(state_o), 5);
        reset = 1'b1;
        step();
        chk("midrst_state", 32'(state_o), 0);
        chk("midrst_saida", 32'(saida), 0);
        chk("midrst_cnt", 32'(trans_cnt), 0);
        reset = 1'b0;
        step();
        chk("post_rst_state", 32'(state_o), 5);
        chk("post_rst_saida", 32'(saida), 5);

        // Self-loop holds state without counting.
        a = 2'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("loop_state", 32'(state_o), 5);
            chk("loop_changed", 32'(changed), 0);
            chk("loop_cnt", 32'(trans_cnt), 1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            run       = ($urandom_range(0, 3) != 0);
            a         = 2'($urandom);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_sel   = 1'($urandom);
            cfg_addr  = 5'($urandom);
            cfg_data  = 3'($urandom);
            clr_cnt   = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
